// File: rtl/rvalid_delay_buffer.sv
// ============================================================================
// Module   : rvalid_delay_buffer
// Brief    : Response-path latency injector. Holds memory read responses and
//            re-presents them to the core, in order, after a programmable delay.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rvalid_delay_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int DELAY_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]        mem_rdata_i,
    input  logic [DELAY_WIDTH-1:0]       delay_cfg_i,
    output logic                         core_rvalid_o,
    output logic [DATA_WIDTH-1:0]        core_rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic                         overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0]  data_q [DEPTH];
    logic [DELAY_WIDTH-1:0] cnt_q  [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [OCC_W-1:0]       occ_q;
    logic                   core_rvalid_q;
    logic [DATA_WIDTH-1:0]  core_rdata_q;
    logic                   overflow_q;

    logic                   pop_d;
    logic                   push_d;
    logic [DELAY_WIDTH-1:0] cnt_init_d;
    logic [PTR_W-1:0]       rel_d   [DEPTH];
    logic [DEPTH-1:0]       valid_d;

    assign pop_d      = (occ_q != '0) && (cnt_q[rd_ptr_q] == '0);
    // A full buffer still accepts a push when the head leaves on the same edge.
    assign push_d     = mem_rvalid_i && ((occ_q != OCC_W'(DEPTH)) || pop_d);
    assign cnt_init_d = (delay_cfg_i == '0) ? '0 : delay_cfg_i - 1'b1;

    // An entry is live when its distance from the read pointer is below occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rel_d[i]   = PTR_W'(i) - rd_ptr_q;
            valid_d[i] = (OCC_W'(rel_d[i]) < occ_q);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_d[i] && (cnt_q[i] != '0)) begin
                cnt_q[i] <= cnt_q[i] - 1'b1;
            end
        end
        if (push_d) begin
            data_q[wr_ptr_q] <= mem_rdata_i;
            cnt_q[wr_ptr_q]  <= cnt_init_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= '0;
            core_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            core_rvalid_q <= pop_d;
            if (pop_d) begin
                core_rdata_q <= data_q[rd_ptr_q];
                rd_ptr_q     <= rd_ptr_q + 1'b1;
            end
            if (push_d) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (push_d && !pop_d) begin
                occ_q <= occ_q + 1'b1;
            end else if (pop_d && !push_d) begin
                occ_q <= occ_q - 1'b1;
            end
            if (mem_rvalid_i && !push_d) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign core_rvalid_o = core_rvalid_q;
    assign core_rdata_o  = core_rdata_q;
    assign occupancy_o   = occ_q;
    assign overflow_o    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_rvalid_delay_buffer.sv
// ============================================================================
// Module   : tb_rvalid_delay_buffer
// Brief    : Self-checking bench; reference model tracks each response's
//            release time in a queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rvalid_delay_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int DLW   = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mem_rvalid_i;
    logic [DW-1:0]   mem_rdata_i;
    logic [DLW-1:0]  delay_cfg_i;
    logic            core_rvalid_o;
    logic [DW-1:0]   core_rdata_o;
    logic [2:0]      occupancy_o;
    logic            overflow_o;

    rvalid_delay_buffer #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .DELAY_WIDTH (DLW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .delay_cfg_i   (delay_cfg_i),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .occupancy_o   (occupancy_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            rdy;
    } ent_t;

    ent_t          q[$];
    int            edge_n = 0;
    int            tests  = 0;
    int            fails  = 0;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic          exp_ovf;

    task automatic check_all(input string tag);
        tests++;
        assert (core_rvalid_o === exp_v) else begin
            fails++;
            $error("FAIL %s rvalid obs=%0b exp=%0b edge=%0d", tag, core_rvalid_o, exp_v, edge_n);
        end
        tests++;
        assert (core_rdata_o === exp_d) else begin
            fails++;
            $error("FAIL %s rdata obs=%h exp=%h edge=%0d", tag, core_rdata_o, exp_d, edge_n);
        end
        tests++;
        assert (occupancy_o === 3'(q.size())) else begin
            fails++;
            $error("FAIL %s occupancy obs=%0d exp=%0d edge=%0d", tag, occupancy_o, q.size(), edge_n);
        end
        tests++;
        assert (overflow_o === exp_ovf) else begin
            fails++;
            $error("FAIL %s overflow obs=%0b exp=%0b edge=%0d", tag, overflow_o, exp_ovf, edge_n);
        end
    endtask

    // One clock edge: drive inputs, advance the model, then compare.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [DLW-1:0] cfg,
                        input logic rn, input string tag);
        logic pop;
        int   dly;
        mem_rvalid_i = v;
        mem_rdata_i  = d;
        delay_cfg_i  = cfg;
        rst_n        = rn;
        @(posedge clk);
        edge_n++;
        if (!rn) begin
            q.delete();
            exp_v   = 1'b0;
            exp_d   = '0;
            exp_ovf = 1'b0;
        end else begin
            pop = (q.size() > 0) && (q[0].rdy <= edge_n);
            exp_v = pop;
            if (pop) begin
                exp_d = q[0].data;
                void'(q.pop_front());
            end
            if (v) begin
                dly = (cfg == 0) ? 1 : int'(cfg);
                if (q.size() < DEPTH) q.push_back('{data: d, rdy: edge_n + dly});
                else exp_ovf = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, tag);
    endtask

    initial begin
        exp_v = 1'b0; exp_d = '0; exp_ovf = 1'b0;
        step(1'b0, '0, '0, 1'b0, "reset");
        step(1'b1, 32'h5555_5555, 4'd1, 1'b0, "reset_drop");
        idle(3, "post_reset");

        // Single response with delay 3
        step(1'b1, 32'hDEAD_BEEF, 4'd3, 1'b1, "single");
        idle(5, "single");

        // Burst of three with delay 2
        step(1'b1, 32'h1, 4'd2, 1'b1, "burst");
        step(1'b1, 32'h2, 4'd2, 1'b1, "burst");
        step(1'b1, 32'h3, 4'd2, 1'b1, "burst");
        idle(5, "burst");

        // Head-of-line blocking
        step(1'b1, 32'hA, 4'd5, 1'b1, "hol");
        step(1'b1, 32'hB, 4'd1, 1'b1, "hol");
        idle(8, "hol");

        // Full with simultaneous pop and push
        for (int i = 0; i < 4; i++) step(1'b1, 32'h20 + i, 4'd4, 1'b1, "full_pp");
        step(1'b1, 32'h24, 4'd4, 1'b1, "full_pp");
        idle(8, "full_pp");

        // Overflow: five responses into four slots
        for (int i = 0; i < 5; i++) step(1'b1, 32'h10 + i, 4'd15, 1'b1, "overflow");
        idle(20, "overflow");

        // Reset mid-flight then zero-delay response
        step(1'b0, '0, '0, 1'b0, "reset2");
        for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + i, 4'd6, 1'b1, "midflight");
        step(1'b0, '0, '0, 1'b0, "reset_mid");
        idle(8, "after_reset");
        step(1'b1, 32'hCAFE_F00D, 4'd0, 1'b1, "cfg0");
        idle(3, "cfg0");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic rv, rn;
            logic [DLW-1:0] cfg;
            rv  = ($urandom_range(0, 99) < 55);
            rn  = ($urandom_range(0, 199) != 0);
            cfg = ($urandom_range(0, 3) == 0) ? DLW'($urandom_range(0, 15))
                                              : DLW'($urandom_range(0, 4));
            step(rv, $urandom, cfg, rn, "random");
        end
        idle(20, "drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rvalid_delay_buffer.md
# rvalid_delay_buffer

Response-path latency injector for the data-memory interface: captures each memory read response (rvalid + rdata) and re-presents it to the core after a runtime-programmable number of cycles, preserving response order. Sits between the memory's response outputs and the core's rvalid/rdata inputs, complementing the request-path delay stage. It is used to model slower memories for tracing and timing experiments. Responses have no backpressure. The block buffers up to DEPTH in-flight responses and flags any loss.

## Interface
- DATA_WIDTH, 32, width of response data.
- DEPTH, 4, number of buffered responses (power of two, ≥2).
- DELAY_WIDTH, 4, width of the delay configuration.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mem_rvalid_i  in  1  memory response valid; one response per cycle max.
- mem_rdata_i  in  DATA_WIDTH  memory response data, valid with mem_rvalid_i.
- delay_cfg_i  in  DELAY_WIDTH  cycles to add; sampled per response at capture.
- core_rvalid_o  out  1  delayed response valid, single-cycle pulse per response.
- core_rdata_o  out  DATA_WIDTH  delayed response data, valid with core_rvalid_o.
- occupancy_o  out  $clog2(DEPTH+1)  entries currently held.
- overflow_o  out  1  sticky: a response was dropped because the buffer was full.

## Operation
- Storage: circular FIFO of DEPTH entries {data, count[DELAY_WIDTH-1:0]}, with wr_ptr and rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
- Push: on an edge with mem_rvalid_i=1 and space available, store mem_rdata_i, set count = max(delay_cfg_i,1)−1, advance wr_ptr, and increment occupancy.
- Counting: every cycle, each valid entry with count≠0 decrements by 1. This applies to all entries, not only the head. Count saturates at 0.
- Pop: on an edge where occupancy≠0 and head count==0:
  - Register core_rvalid_o=1 and core_rdata_o=head data.
  - Advance rd_ptr and decrement occupancy.
  - At most one pop per edge.
- If no pop occurs on an edge, core_rvalid_o is 0 on that edge. core_rdata_o holds its last value.
- Ordering: strictly FIFO. An entry whose count reaches 0 behind a non-ready head waits; release is head-of-line.
- Space: a push is accepted when occupancy<DEPTH, or when occupancy==DEPTH and a pop occurs on the same edge. Simultaneous push+pop leaves occupancy unchanged.
- Overflow: if mem_rvalid_i=1 and no space is available, the response is dropped, overflow_o sets to 1, and FIFO state is unchanged. overflow_o stays 1 until reset.
- Empty: push into an empty buffer cannot pop on the same edge. A newly pushed entry is never popped on its push edge.
- Reset (rst_n=0 at an edge): flush pointers and occupancy to 0, and set core_rvalid_o=0, core_rdata_o=0, overflow_o=0, occupancy_o=0.
  - Any in-flight responses are discarded, including one presented on the reset edge.
  - Entry storage need not be cleared.

## Timing
- Let a response be captured at edge k with d=max(delay_cfg_i,1), and let the buffer be otherwise idle. core_rvalid_o is 1 for exactly the cycle following edge k+d.
  - d=1 gives 1-cycle registered pass-through.
  - delay_cfg_i=0 behaves identically to 1.
- Back-to-back responses with equal d produce back-to-back core_rvalid_o pulses with the same spacing as the input.
- Head-of-line case: if a later entry becomes ready before the head, it is released on the edge after the head pops, or later.
- occupancy_o and overflow_o are registered and reflect the state after the current edge's push and pop.
- delay_cfg_i changes affect only responses captured after the change.

## Test plan
- Single response, DEPTH=4: rdata=0xDEADBEEF, delay_cfg_i=3, captured at edge 10 -> core_rvalid_o high only after edge 13, core_rdata_o=0xDEADBEEF, occupancy_o 1 for three cycles then 0.
- Burst: three consecutive responses 0x1, 0x2, 0x3 at edges 20–22 with delay 2 -> pulses after edges 22, 23, 24 in order.
- Head-of-line: A (0xA) delay 5 at edge 30, B (0xB) delay 1 at edge 31 -> A released after edge 35, B after edge 36, never B before A.
- Overflow: delay 15, five consecutive responses 0x10–0x14 -> occupancy_o=4, overflow_o=1 after the fifth edge. Outputs are 0x10–0x13 only, and overflow_o remains 1.
- Full + simultaneous pop/push: fill 4 entries so the head's count reaches 0 on the same edge a fifth response arrives -> head popped, fifth accepted, occupancy_o stays 4, overflow_o=0.
- Reset mid-operation: 3 entries in flight, rst_n=0 for one edge -> all outputs 0 the next cycle and no stale pulses afterward. delay_cfg_i=0 response after reset -> pulse 1 cycle after capture.
